fsm_moore_prog: RTL and testbench

- Parametrised, table-driven Moore state machine; next-state and output tables are programmable at run time through a config write port.
- Successor to the fixed 5-state Moore test FSM: generalised state/input/output counts, run enable, range checking and error flags.
- Sits between the stimulus/config driver and the checker in the FSM verification fabric; one instance models any Moore FSM up to NUM_STATES x NUM_INPUTS.

---
 rtl/fsm_pkg.sv | 33 +++
 rtl/fsm_prog_table.sv | 64 ++++++
 rtl/fsm_moore_prog.sv | 119 +++++++++++
 tb/tb_fsm_moore_prog.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pkg
// Shared constants and helpers for the programmable Moore FSM.
//   CFG_NS / CFG_OUT : values of cfg_sel selecting the next-state or output table
//   clog2            : ceiling log2 used for parameter legality checks
//   max2             : larger of two ints (sizes the config data bus)
//   params_ok        : true when a parameter set describes a buildable FSM
// -----------------------------------------------------------------------------
package fsm_pkg;

  localparam logic CFG_NS  = 1'b0;
  localparam logic CFG_OUT = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Legal range: 2..16 states and inputs, and both encodings wide enough.
  function automatic bit params_ok(input int num_states, input int num_inputs,
                                   input int in_w, input int st_w);
    return (num_states >= 2) && (num_states <= 16) &&
           (num_inputs >= 2) && (num_inputs <= 16) &&
           (in_w >= clog2(num_inputs)) && (st_w >= clog2(num_states));
  endfunction

endpackage

// File: rtl/fsm_prog_table.sv
// -----------------------------------------------------------------------------
// fsm_prog_table
// Storage for the next-state table and the Moore output table.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   we_i, sel_i        : write strobe (already range-checked), table select
//   row_i, col_i       : source state and input symbol of the entry to write
//   ns_data_i          : next-state value for the ns table
//   out_data_i         : output word for the out table
//   rd_state_i, rd_in_i: asynchronous read address
//   rd_ns_o, rd_out_o  : ns_tbl[rd_state][rd_in], out_tbl[rd_state]
// Reset loads every ns entry with its own row index (self-loop) and clears
// every output word.
// -----------------------------------------------------------------------------
module fsm_prog_table
  import fsm_pkg::*;
#(
  parameter int ST_W  = 3,
  parameter int IN_W  = 3,
  parameter int OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic             sel_i,
  input  logic [ST_W-1:0]  row_i,
  input  logic [IN_W-1:0]  col_i,
  input  logic [ST_W-1:0]  ns_data_i,
  input  logic [OUT_W-1:0] out_data_i,
  input  logic [ST_W-1:0]  rd_state_i,
  input  logic [IN_W-1:0]  rd_in_i,
  output logic [ST_W-1:0]  rd_ns_o,
  output logic [OUT_W-1:0] rd_out_o
);

  // Arrays span the full code space so any encoded address indexes cleanly;
  // rows/columns beyond the legal counts are never written and never steer
  // the state register, because the top level filters illegal codes.
  localparam int ROWS = 1 << ST_W;
  localparam int COLS = 1 << IN_W;

  logic [ST_W-1:0]  ns_q  [ROWS][COLS];
  logic [OUT_W-1:0] out_q [ROWS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          ns_q[r][c] <= ST_W'(r);
        end
        out_q[r] <= '0;
      end
    end else if (we_i) begin
      if (sel_i == CFG_NS) begin
        ns_q[row_i][col_i] <= ns_data_i;
      end else begin
        out_q[row_i] <= out_data_i;
      end
    end
  end

  assign rd_ns_o  = ns_q[rd_state_i][rd_in_i];
  assign rd_out_o = out_q[rd_state_i];

endmodule

// File: rtl/fsm_moore_prog.sv
// -----------------------------------------------------------------------------
// fsm_moore_prog
// Table-driven Moore FSM whose transition and output tables are written at
// run time.
//   clk, reset : clock, synchronous active-high reset (clears tables too)
//   run_en, in : advance one step on input symbol `in`
//   cfg_we, cfg_sel, cfg_state, cfg_in, cfg_data : table write port
//   state      : current state register (also the debug view of the FSM)
//   out        : Moore output, out_tbl[state]
//   in_err     : one-cycle pulse after an illegal input was presented
//   cfg_err    : one-cycle pulse after a config write was rejected
// Strobe semantics: run_en and cfg_we are single-cycle qualifiers with no
// back-pressure; whatever they qualify is committed on that rising edge and
// both may be active together. A step reads the table value from before any
// write landing on the same edge.
// -----------------------------------------------------------------------------
module fsm_moore_prog
  import fsm_pkg::*;
#(
  parameter  int NUM_STATES = 5,
  parameter  int NUM_INPUTS = 5,
  parameter  int IN_W       = 3,
  parameter  int OUT_W      = 4,
  parameter  int ST_W       = 3,
  localparam int CFG_W      = max2(ST_W, OUT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic [IN_W-1:0]  in,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [ST_W-1:0]  cfg_state,
  input  logic [IN_W-1:0]  cfg_in,
  input  logic [CFG_W-1:0] cfg_data,
  output logic [ST_W-1:0]  state,
  output logic [OUT_W-1:0] out,
  output logic             in_err,
  output logic             cfg_err
);

  if (!params_ok(NUM_STATES, NUM_INPUTS, IN_W, ST_W)) begin : g_bad_params
    $error("fsm_moore_prog: illegal NUM_STATES/NUM_INPUTS/IN_W/ST_W combination");
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic             in_err_q, in_err_d;
  logic             cfg_err_q, cfg_err_d;
  logic [ST_W-1:0]  tbl_ns;
  logic [OUT_W-1:0] tbl_out;
  logic             in_ok, cfg_ok, tbl_we;

  // Range checks against the legal counts; widened so that a count equal to
  // 2**width still compares correctly.
  always_comb begin
    in_ok  = int'(in) < NUM_INPUTS;
    cfg_ok = (int'(cfg_state) < NUM_STATES) &&
             ((cfg_sel == CFG_OUT) ||
              ((int'(cfg_in) < NUM_INPUTS) && (int'(cfg_data) < NUM_STATES)));
    tbl_we = cfg_we && cfg_ok;
  end

  fsm_prog_table #(
    .ST_W  (ST_W),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_table (
    .clk_i      (clk),
    .reset_i    (reset),
    .we_i       (tbl_we),
    .sel_i      (cfg_sel),
    .row_i      (cfg_state),
    .col_i      (cfg_in),
    .ns_data_i  (cfg_data[ST_W-1:0]),
    .out_data_i (cfg_data[OUT_W-1:0]),
    .rd_state_i (state_q),
    .rd_in_i    (in),
    .rd_ns_o    (tbl_ns),
    .rd_out_o   (tbl_out)
  );

  // State register and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      in_err_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_err_q  <= in_err_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic. An illegal symbol leaves the state where it is; since
  // every accepted ns entry is < NUM_STATES the state stays legal.
  always_comb begin
    state_d   = state_q;
    in_err_d  = 1'b0;
    cfg_err_d = cfg_we && !cfg_ok;
    if (run_en) begin
      if (in_ok) begin
        state_d = tbl_ns;
      end else begin
        in_err_d = 1'b1;
      end
    end
  end

  // Moore outputs: the output word is looked up from the registered state
  // with no extra pipeline stage.
  always_comb begin
    state   = state_q;
    out     = tbl_out;
    in_err  = in_err_q;
    cfg_err = cfg_err_q;
  end

endmodule

// File: tb/tb_fsm_moore_prog.sv
module tb_fsm_moore_prog;

  localparam int NS  = 5;
  localparam int NI  = 5;
  localparam int EXP_W = 3 + 4 + 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_en = 1'b0;
  logic [2:0] in_sym = '0;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [2:0] cfg_state = '0;
  logic [2:0] cfg_in = '0;
  logic [3:0] cfg_data = '0;
  logic [2:0] state;
  logic [3:0] out;
  logic       in_err;
  logic       cfg_err;

  always #5 clk = ~clk;

  fsm_moore_prog dut (
    .clk       (clk),
    .reset     (reset),
    .run_en    (run_en),
    .in        (in_sym),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_state (cfg_state),
    .cfg_in    (cfg_in),
    .cfg_data  (cfg_data),
    .state     (state),
    .out       (out),
    .in_err    (in_err),
    .cfg_err   (cfg_err)
  );

  // ---------------- reference model ----------------
  int m_ns [NS][NI];
  int m_out [NS];
  int m_state;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  // Applies one cycle of stimulus at the falling edge and pushes the values
  // the DUT must show after the following rising edge.
  task automatic drive(input bit r, input bit run, input int inp, input bit we,
                       input bit sel, input int cs, input int ci, input int d);
    int nxt;
    bit ie, ce, ok;
    @(negedge clk);
    reset = r; run_en = run; in_sym = 3'(inp);
    cfg_we = we; cfg_sel = sel; cfg_state = 3'(cs); cfg_in = 3'(ci);
    cfg_data = 4'(d);
    ie = 1'b0;
    ce = 1'b0;
    if (r) begin
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < NI; i++) m_ns[s][i] = s;
        m_out[s] = 0;
      end
      m_state = 0;
    end else begin
      nxt = m_state;
      if (run) begin
        if (inp < NI) nxt = m_ns[m_state][inp];
        else ie = 1'b1;
      end
      if (we) begin
        if (sel) ok = (cs < NS);
        else     ok = (cs < NS) && (ci < NI) && (d < NS);
        ce = !ok;
        if (ok) begin
          if (sel) m_out[cs] = d;
          else     m_ns[cs][ci] = d;
        end
      end
      m_state = nxt;
    end
    exp_q.push_back({3'(m_state), 4'(m_out[m_state]), ie, ce});
  endtask

  task automatic step(input int inp);
    drive(1'b0, 1'b1, inp, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wr_ns(input int s, input int i, input int d);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, s, i, d);
  endtask

  task automatic wr_out(input int s, input int d);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, s, 0, d);
  endtask

  // Directed check against hand-derived constants after the edge that
  // commits the most recent drive.
  task automatic expect_now(input string name, input int st, input int o);
    @(posedge clk);
    #2;
    checks++;
    if (int'(state) != st || int'(out) != o) begin
      errors++;
      $display("FAIL %s: got state=%0d out=%0d, expected state=%0d out=%0d",
               name, state, out, st, o);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {state, out, in_err, cfg_err};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got state=%0d out=%0d in_err=%0b cfg_err=%0b, expected state=%0d out=%0d in_err=%0b cfg_err=%0b",
                   $time, got[8:6], got[5:2], got[1], got[0],
                   e[8:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int d;
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    expect_now("reset", 0, 0);

    // Default tables self-loop on every input.
    for (int i = 0; i < NI; i++) step(i);
    expect_now("self_loop", 0, 0);

    // Ring 0->1->2->3->4->0 on input 1, out = state + 8.
    for (int s = 0; s < NS; s++) wr_ns(s, 1, (s + 1) % NS);
    for (int s = 0; s < NS; s++) wr_out(s, s + 8);
    for (int k = 0; k < 6; k++) step(1);
    expect_now("ring", 1, 9);

    // Illegal input holds state and pulses in_err.
    step(1);
    step(6);
    expect_now("illegal_hold", 2, 10);
    idle();

    // Rejected writes leave the tables untouched.
    wr_out(5, 3);
    wr_ns(0, 1, 7);
    step(1);
    expect_now("after_rejects", 3, 11);

    // Step and write to the same entry on one edge.
    step(1);
    step(1);
    drive(1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 1, 3);
    expect_now("same_edge_old", 1, 9);
    for (int k = 0; k < 4; k++) step(1);
    step(1);
    expect_now("same_edge_new", 3, 11);

    // Reset mid-ring wipes the tables.
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    expect_now("mid_reset", 0, 0);
    step(1);
    expect_now("cleared", 0, 0);

    // Output write for the current state.
    wr_out(0, 5);
    expect_now("out_write_cur", 0, 5);

    // Illegal input together with a rejected write.
    drive(1'b0, 1'b1, 7, 1'b1, 1'b0, 6, 0, 0);
    idle();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      d = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 15);
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            d);
    end
    idle();

    // Bounded drain of the expected queue.
    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #3;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
